// File: rtl/timer_pkg.sv
// Shared definitions for the machine-timer compare block: register indices,
// CTRL bit positions and the compare state encoding.
`timescale 1ns/1ps
package timer_pkg;

  localparam logic [2:0] REG_CMP_LO  = 3'd0;
  localparam logic [2:0] REG_CMP_HI  = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_PERIOD  = 3'd3;
  localparam logic [2:0] REG_SNAP_LO = 3'd4;
  localparam logic [2:0] REG_SNAP_HI = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PER  = 1;
  localparam int CTRL_PEND = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    HALF  = 2'd3
  } cmp_state_t;

endpackage

// File: rtl/timer_snap.sv
// Atomic mtime snapshot: reading SNAP_LO captures the upper word so a later
// SNAP_HI read pairs with it, regardless of carries in between.
`timescale 1ns/1ps
module timer_snap
  import timer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        rd,
  input  logic [2:0]  idx,
  input  logic [63:0] mtime,
  output logic [31:0] rdata
);

  logic [31:0] snap_hi;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        snap_hi <= '0;
    else if (rd && idx == REG_SNAP_LO) snap_hi <= mtime[63:32];
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_SNAP_LO: rdata = mtime[31:0];
      REG_SNAP_HI: rdata = snap_hi;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_cmp_ctrl.sv
// Machine-timer compare/interrupt controller: 64-bit compare against mtime,
// one-shot or periodic reload, torn-write protection and snapshot reads.
`timescale 1ns/1ps
module timer_cmp_ctrl
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_PERIOD = 32'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [63:0] mtime,
  output logic [31:0] dout,
  output logic        irq
);

  cmp_state_t  state, state_d;
  logic [63:0] cmp;
  logic [31:0] period;
  logic        en, periodic, pending;
  logic [31:0] snap_rdata;

  logic [2:0] idx;
  logic       wr, rd, wr_lo, wr_hi, wr_ctrl, wr_per, hit;
  logic       unused_addr;

  assign idx         = addr[4:2];
  assign unused_addr = ^{addr[31:5], addr[1:0]};
  assign wr          = sel & we;
  assign rd          = sel & ~we;
  assign wr_lo       = wr && idx == REG_CMP_LO;
  assign wr_hi       = wr && idx == REG_CMP_HI;
  assign wr_ctrl     = wr && idx == REG_CTRL;
  assign wr_per      = wr && idx == REG_PERIOD;
  assign hit         = (state == ARMED) && (mtime >= cmp);

  // Bus writes override the FSM; an en=0 write overrides everything.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (wr_ctrl && din[CTRL_EN]) state_d = ARMED;
      ARMED:   if (hit && !periodic)        state_d = FIRED;
      FIRED:   if (wr_hi)                   state_d = ARMED;
      HALF:    if (wr_hi)                   state_d = ARMED;
      default: state_d = IDLE;
    endcase
    if (wr_hi && state != IDLE)                  state_d = ARMED;
    if (wr_lo && (state == ARMED || state == FIRED || state == HALF))
      state_d = HALF;
    if (wr_ctrl && !din[CTRL_EN])                state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // A bus write to either half discards any reload in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                cmp <= '1;
    else if (wr_lo)            cmp[31:0]  <= din;
    else if (wr_hi)            cmp[63:32] <= din;
    else if (hit && periodic)  cmp <= cmp + {32'b0, period};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
      period   <= RESET_PERIOD;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en       <= din[CTRL_EN];
        periodic <= din[CTRL_PER];
      end
      if (wr_per) period <= din;
      pending <= (pending & ~(wr_ctrl & din[CTRL_PEND])) | hit;
      irq     <= pending & en;
    end
  end

  timer_snap u_snap (
    .clock (clock),
    .reset (reset),
    .rd    (rd),
    .idx   (idx),
    .mtime (mtime),
    .rdata (snap_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dout <= '0;
    else if (rd) begin
      case (idx)
        REG_CMP_LO:  dout <= cmp[31:0];
        REG_CMP_HI:  dout <= cmp[63:32];
        REG_CTRL:    dout <= {29'b0, pending, periodic, en};
        REG_PERIOD:  dout <= period;
        REG_SNAP_LO,
        REG_SNAP_HI: dout <= snap_rdata;
        default:     dout <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmp_ctrl.sv
// Directed bench for timer_cmp_ctrl: reset, one-shot, periodic, torn write,
// snapshot, write/reload collision, zero period, fire-vs-W1C and async reset.
`timescale 1ns/1ps
module tb_timer_cmp_ctrl;
  import timer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [63:0] mtime = '0;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_CMP_LO = 32'h00, A_CMP_HI = 32'h04, A_CTRL = 32'h08,
                          A_PERIOD = 32'h0C, A_SNAP_LO = 32'h10, A_SNAP_HI = 32'h14;

  timer_cmp_ctrl dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .din(din), .mtime(mtime), .dout(dout), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    sel = 0; we = 0; mtime = '0; reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    sel = 1; we = 1; addr = a; din = d;
    @(negedge clock);
    sel = 0; we = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    sel = 1; we = 0; addr = a;
    @(negedge clock);
    sel = 0;
    d = dout;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_read(A_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", r); end
    bus_read(A_CMP_HI, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got=%h exp=ffffffff", r); end
    bus_read(A_PERIOD, r);
    checks++; if (r !== 32'd1000) begin errors++; $display("FAIL reset_period got=%0d exp=1000", r); end
    repeat (3) @(negedge clock);
    checks++; if (dout !== 32'd1000) begin errors++; $display("FAIL dout_hold got=%0d exp=1000", dout); end
  endtask

  task automatic test_one_shot();
    logic ok;
    do_reset();
    bus_write(A_CMP_LO, 32'd100);
    bus_write(A_CMP_HI, 32'd0);
    mtime = 64'd90;
    bus_write(A_CTRL, 32'h1);
    for (int m = 91; m <= 99; m++) begin
      @(negedge clock); mtime = 64'(m);
    end
    @(negedge clock);
    checks++; if (dut.pending !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL oneshot_early pend=%b irq=%b exp=0/0", dut.pending, irq); end
    mtime = 64'd100;
    @(negedge clock);
    checks++; if (dut.pending !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL oneshot_pend pend=%b irq=%b exp=1/0", dut.pending, irq); end
    checks++; if (dut.state !== FIRED) begin errors++; $display("FAIL oneshot_state got=%0d exp=%0d", dut.state, FIRED); end
    mtime = 64'd101;
    @(negedge clock);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got=%b exp=1", irq); end
    bus_write(A_CTRL, 32'h5);
    checks++; if (dut.pending !== 1'b0 || irq !== 1'b1) begin errors++; $display("FAIL w1c_edge pend=%b irq=%b exp=0/1", dut.pending, irq); end
    ok = 1'b1;
    for (int m = 102; m <= 110; m++) begin
      @(negedge clock);
      if (irq !== 1'b0) ok = 1'b0;
      mtime = 64'(m);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL w1c_irq_low got=irq_seen exp=irq_low"); end
  endtask

  task automatic test_periodic();
    logic [63:0] fires [3];
    int n;
    logic [31:0] r;
    n = 0;
    do_reset();
    bus_write(A_PERIOD, 32'd20);
    bus_write(A_CMP_LO, 32'd50);
    bus_write(A_CMP_HI, 32'd0);
    mtime = 64'd40;
    bus_write(A_CTRL, 32'h3);
    for (int m = 41; m <= 100; m++) begin
      @(negedge clock);
      if (dut.pending === 1'b1) begin
        if (n < 3) fires[n] = mtime;
        n++;
        sel = 1; we = 1; addr = A_CTRL; din = 32'h7;
      end else begin
        sel = 0; we = 0;
      end
      mtime = 64'(m);
    end
    @(negedge clock); sel = 0; we = 0;
    checks++; if (n !== 3) begin errors++; $display("FAIL periodic_count got=%0d exp=3", n); end
    if (n >= 3) begin
      checks++; if (fires[0] !== 64'd50 || fires[1] !== 64'd70 || fires[2] !== 64'd90) begin
        errors++; $display("FAIL periodic_times got=%0d,%0d,%0d exp=50,70,90", fires[0], fires[1], fires[2]);
      end
    end
    bus_read(A_CMP_LO, r);
    checks++; if (r !== 32'd110) begin errors++; $display("FAIL periodic_cmp got=%0d exp=110", r); end
  endtask

  task automatic test_torn_write();
    logic ok;
    do_reset();
    bus_write(A_CMP_LO, 32'hFFFF_FFFF);
    bus_write(A_CMP_HI, 32'h1);
    mtime = 64'h1_0000_0010;
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clock);
    checks++; if (dut.pending !== 1'b0) begin errors++; $display("FAIL torn_armed got=%b exp=0", dut.pending); end
    bus_write(A_CMP_LO, 32'h0);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (dut.pending !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1 || dut.state !== HALF) begin errors++; $display("FAIL torn_half ok=%b state=%0d exp=1/%0d", ok, dut.state, HALF); end
    bus_write(A_CMP_HI, 32'h1);
    checks++; if (dut.pending !== 1'b0) begin errors++; $display("FAIL torn_hi_edge got=%b exp=0", dut.pending); end
    @(negedge clock);
    checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL torn_fire got=%b exp=1", dut.pending); end
  endtask

  task automatic test_snapshot();
    logic [31:0] lo, hi;
    do_reset();
    mtime = 64'h0000_0001_FFFF_FFFF;
    bus_read(A_SNAP_LO, lo);
    mtime = mtime + 64'd2;
    bus_read(A_SNAP_HI, hi);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL snap_hi got=%h exp=1", hi); end
  endtask

  task automatic test_write_vs_reload();
    logic [31:0] r;
    do_reset();
    bus_write(A_PERIOD, 32'd20);
    bus_write(A_CMP_LO, 32'd10);
    bus_write(A_CMP_HI, 32'd0);
    mtime = 64'd5;
    bus_write(A_CTRL, 32'h3);
    @(negedge clock);
    mtime = 64'd10; sel = 1; we = 1; addr = A_CMP_LO; din = 32'd500;
    @(negedge clock);
    sel = 0; we = 0;
    checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL collide_pend got=%b exp=1", dut.pending); end
    bus_read(A_CMP_LO, r);
    checks++; if (r !== 32'd500) begin errors++; $display("FAIL collide_cmp_lo got=%0d exp=500", r); end
    bus_read(A_CMP_HI, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL collide_cmp_hi got=%0d exp=0", r); end
  endtask

  task automatic test_period_zero();
    logic [31:0] r;
    do_reset();
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CMP_LO, 32'd10);
    bus_write(A_CMP_HI, 32'd0);
    mtime = 64'd10;
    bus_write(A_CTRL, 32'h3);
    @(negedge clock);
    checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL pzero_pend got=%b exp=1", dut.pending); end
    bus_write(A_CTRL, 32'h7);
    checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL pzero_reassert got=%b exp=1", dut.pending); end
    bus_read(A_CMP_LO, r);
    checks++; if (r !== 32'd10) begin errors++; $display("FAIL pzero_cmp got=%0d exp=10", r); end
  endtask

  task automatic test_w1c_fire_and_reset();
    logic [31:0] r;
    do_reset();
    bus_write(A_CMP_LO, 32'd100);
    bus_write(A_CMP_HI, 32'd0);
    mtime = 64'd50;
    bus_write(A_CTRL, 32'h1);
    @(negedge clock);
    mtime = 64'd100; sel = 1; we = 1; addr = A_CTRL; din = 32'h5;
    @(negedge clock);
    sel = 0; we = 0;
    checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL fire_beats_w1c got=%b exp=1", dut.pending); end
    @(negedge clock);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fire_irq got=%b exp=1", irq); end
    #2 reset = 0;
    #1;
    checks++; if (irq !== 1'b0 || dut.pending !== 1'b0) begin errors++; $display("FAIL async_reset irq=%b pend=%b exp=0/0", irq, dut.pending); end
    @(negedge clock);
    reset = 1;
    bus_read(A_CMP_LO, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp got=%h exp=ffffffff", r); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_torn_write();
    test_snapshot();
    test_write_vs_reload();
    test_period_zero();
    test_w1c_fire_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
